// File: rtl/cache_walker_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_walker_pkg
// Description : Shared types and helpers for the cache destination tile walker.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_walker_pkg;

  localparam int C_L_H_SIZE_DEFAULT = 3;
  localparam int C_L_V_SIZE_DEFAULT = 3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WALK = 1'b1
  } walk_state_t;

  // Width of a tile index derived from a pixel coordinate width.
  function automatic int tile_idx_wdth(input int addr_wdth, input int log2_tile);
    return addr_wdth - log2_tile;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tile_range_calc.sv
`default_nettype none
// ============================================================================
// Module      : tile_range_calc
// Description : Per-axis first/last overlapped tile index, clipped to picture.
// Revision    : 1.0 - initial release
// ============================================================================
module tile_range_calc #(
  parameter int ADDR_WDTH = 12,
  parameter int DIM_WDTH  = 7,
  parameter int SHIFT     = 3,
  parameter int IDX_WDTH  = ADDR_WDTH - SHIFT
) (
  input  logic [ADDR_WDTH-1:0] start,
  input  logic [DIM_WDTH-1:0]  dim,
  input  logic [IDX_WDTH-1:0]  pic_tiles,
  output logic [IDX_WDTH-1:0]  ts,
  output logic [IDX_WDTH-1:0]  te
);

  logic [ADDR_WDTH:0]  w_end_px;
  logic [IDX_WDTH:0]   w_te_raw;
  logic [IDX_WDTH-1:0] w_ts_raw;
  logic [IDX_WDTH-1:0] w_pic_max;

  // One extra bit keeps blocks hanging off the right/bottom edge from wrapping.
  assign w_end_px  = {1'b0, start} + (ADDR_WDTH+1)'(dim);
  assign w_te_raw  = (IDX_WDTH+1)'(w_end_px >> SHIFT);
  assign w_ts_raw  = IDX_WDTH'(start >> SHIFT);
  assign w_pic_max = pic_tiles - IDX_WDTH'(1);

  assign te = (w_te_raw > {1'b0, w_pic_max}) ? w_pic_max : w_te_raw[IDX_WDTH-1:0];
  assign ts = (w_ts_raw > w_pic_max) ? w_pic_max : w_ts_raw;

endmodule
`default_nettype wire

// File: rtl/cache_dest_tile_walker.sv
`default_nettype none
// ============================================================================
// Module      : cache_dest_tile_walker
// Description : Walks every cache tile a reference block overlaps, raster order.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_dest_tile_walker
  import cache_walker_pkg::*;
#(
  parameter int X_ADDR_WDTH = 12,
  parameter int Y_ADDR_WDTH = 12,
  parameter int C_L_H_SIZE  = C_L_H_SIZE_DEFAULT,
  parameter int C_L_V_SIZE  = C_L_V_SIZE_DEFAULT,
  parameter int DIM_WDTH    = 7,
  parameter int CNT_WDTH    = 12
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              abort,
  input  logic [X_ADDR_WDTH-C_L_H_SIZE-1:0] pic_w_tiles,
  input  logic [Y_ADDR_WDTH-C_L_V_SIZE-1:0] pic_h_tiles,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic [X_ADDR_WDTH-1:0]            start_x,
  input  logic [Y_ADDR_WDTH-1:0]            start_y,
  input  logic [DIM_WDTH-1:0]               blk_width,
  input  logic [DIM_WDTH-1:0]               blk_height,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [X_ADDR_WDTH-C_L_H_SIZE-1:0] x_addr,
  output logic [Y_ADDR_WDTH-C_L_V_SIZE-1:0] y_addr,
  output logic                              out_first,
  output logic                              out_last,
  output logic [CNT_WDTH-1:0]               tile_count
);

  localparam int c_xt_wdth = tile_idx_wdth(X_ADDR_WDTH, C_L_H_SIZE);
  localparam int c_yt_wdth = tile_idx_wdth(Y_ADDR_WDTH, C_L_V_SIZE);

  walk_state_t          r_state;
  walk_state_t          w_state_nxt;
  logic [c_xt_wdth-1:0] w_xs, w_xe, r_xs, r_xe, r_x;
  logic [c_yt_wdth-1:0] w_ys, w_ye, r_ys, r_ye, r_y;
  logic [CNT_WDTH-1:0]  r_count;
  logic                 w_accept;
  logic                 w_beat;

  tile_range_calc #(
    .ADDR_WDTH (X_ADDR_WDTH),
    .DIM_WDTH  (DIM_WDTH),
    .SHIFT     (C_L_H_SIZE),
    .IDX_WDTH  (c_xt_wdth)
  ) u_x_range (
    .start     (start_x),
    .dim       (blk_width),
    .pic_tiles (pic_w_tiles),
    .ts        (w_xs),
    .te        (w_xe)
  );

  tile_range_calc #(
    .ADDR_WDTH (Y_ADDR_WDTH),
    .DIM_WDTH  (DIM_WDTH),
    .SHIFT     (C_L_V_SIZE),
    .IDX_WDTH  (c_yt_wdth)
  ) u_y_range (
    .start     (start_y),
    .dim       (blk_height),
    .pic_tiles (pic_h_tiles),
    .ts        (w_ys),
    .te        (w_ye)
  );

  assign w_accept = req_valid & req_ready;
  assign w_beat   = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset || abort) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (req_valid) w_state_nxt = WALK;
      WALK:    if (w_beat && out_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Flags are position-based: each tile position is visited exactly once.
  always_comb begin
    req_ready = (r_state == IDLE);
    out_valid = (r_state == WALK);
    out_first = (r_state == WALK) && (r_x == r_xs) && (r_y == r_ys);
    out_last  = (r_state == WALK) && (r_x == r_xe) && (r_y == r_ye);
  end

  always_ff @(posedge clk) begin
    if (reset || abort) begin
      r_xs    <= '0;
      r_xe    <= '0;
      r_ys    <= '0;
      r_ye    <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_count <= '0;
    end else if (w_accept) begin
      r_xs    <= w_xs;
      r_xe    <= w_xe;
      r_ys    <= w_ys;
      r_ye    <= w_ye;
      r_x     <= w_xs;
      r_y     <= w_ys;
      r_count <= '0;
    end else if (w_beat) begin
      if (r_count != '1) begin
        r_count <= r_count + CNT_WDTH'(1);
      end
      if (r_x != r_xe) begin
        r_x <= r_x + c_xt_wdth'(1);
      end else if (r_y != r_ye) begin
        r_x <= r_xs;
        r_y <= r_y + c_yt_wdth'(1);
      end
    end
  end

  assign x_addr     = r_x;
  assign y_addr     = r_y;
  assign tile_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_cache_dest_tile_walker.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_dest_tile_walker
// Description : Randomized bench with a tile-list reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_dest_tile_walker;

  localparam int XW = 12;
  localparam int YW = 12;
  localparam int H  = 3;
  localparam int V  = 3;
  localparam int DW = 7;
  localparam int CW = 12;
  localparam int XT = XW - H;
  localparam int YT = YW - V;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          abort = 1'b0;
  logic [XT-1:0] pic_w_tiles = XT'(64);
  logic [YT-1:0] pic_h_tiles = YT'(64);
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [XW-1:0] start_x = '0;
  logic [YW-1:0] start_y = '0;
  logic [DW-1:0] blk_width = '0;
  logic [DW-1:0] blk_height = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [XT-1:0] x_addr;
  logic [YT-1:0] y_addr;
  logic          out_first;
  logic          out_last;
  logic [CW-1:0] tile_count;

  cache_dest_tile_walker #(
    .X_ADDR_WDTH (XW),
    .Y_ADDR_WDTH (YW),
    .C_L_H_SIZE  (H),
    .C_L_V_SIZE  (V),
    .DIM_WDTH    (DW),
    .CNT_WDTH    (CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .abort       (abort),
    .pic_w_tiles (pic_w_tiles),
    .pic_h_tiles (pic_h_tiles),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .start_x     (start_x),
    .start_y     (start_y),
    .blk_width   (blk_width),
    .blk_height  (blk_height),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .x_addr      (x_addr),
    .y_addr      (y_addr),
    .out_first   (out_first),
    .out_last    (out_last),
    .tile_count  (tile_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    bit first;
    bit last;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    exp_cnt = 0;
  bit    post_clear = 1'b1;
  bit    started = 1'b0;
  bit    m_walk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s timed out at %0t", name, $time);
  endtask

  // Overlap by the inclusive-end rule, then clamp into the picture.
  function automatic void axis_range(input int s, input int d, input int sh, input int pt,
                                     output int ts, output int te);
    ts = -1;
    te = -1;
    for (int t = 0; t < 1024; t++) begin
      if ((t << sh) <= s + d && ((t + 1) << sh) > s) begin
        if (ts < 0) ts = t;
        te = t;
      end
    end
    if (ts > pt - 1) ts = pt - 1;
    if (te > pt - 1) te = pt - 1;
  endfunction

  function automatic void build(input int sx, input int sy, input int w, input int h,
                                input int pw, input int ph);
    int xs, xe, ys, ye;
    beat_t b;
    exp_q.delete();
    axis_range(sx, w, H, pw, xs, xe);
    axis_range(sy, h, V, ph, ys, ye);
    for (int yy = ys; yy <= ye; yy++) begin
      for (int xx = xs; xx <= xe; xx++) begin
        b.x = xx;
        b.y = yy;
        b.first = (xx == xs) && (yy == ys);
        b.last  = (xx == xe) && (yy == ye);
        exp_q.push_back(b);
      end
    end
  endfunction

  always @(negedge clk) begin
    if (started) begin
      m_walk = (exp_q.size() > 0);
      chk("req_ready", req_ready, 32'(!m_walk));
      chk("out_valid", out_valid, 32'(m_walk));
      if (m_walk) begin
        chk("x_addr", 32'(x_addr), exp_q[0].x);
        chk("y_addr", 32'(y_addr), exp_q[0].y);
        chk("out_first", out_first, 32'(exp_q[0].first));
        chk("out_last", out_last, 32'(exp_q[0].last));
        chk("tile_count", 32'(tile_count), exp_cnt);
      end else begin
        chk("out_first_idle", out_first, 0);
        chk("out_last_idle", out_last, 0);
        if (post_clear) begin
          chk("x_addr_clr", 32'(x_addr), 0);
          chk("y_addr_clr", 32'(y_addr), 0);
          chk("tile_count_clr", 32'(tile_count), 0);
        end
      end
      if (reset || abort) begin
        exp_q.delete();
        exp_cnt = 0;
        post_clear = 1'b1;
      end else begin
        if (m_walk && out_ready) begin
          void'(exp_q.pop_front());
          exp_cnt = (exp_cnt + 1 > (1 << CW) - 1) ? (1 << CW) - 1 : exp_cnt + 1;
        end
        if (!m_walk && req_valid) begin
          build(int'(start_x), int'(start_y), int'(blk_width), int'(blk_height),
                int'(pic_w_tiles), int'(pic_h_tiles));
          exp_cnt = 0;
          post_clear = 1'b0;
        end
      end
    end
  end

  task automatic send(input int sx, input int sy, input int w, input int h);
    int n;
    n = 0;
    start_x    = XW'(sx);
    start_y    = YW'(sy);
    blk_width  = DW'(w);
    blk_height = DW'(h);
    req_valid  = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 3000);
    if (n >= 3000) timeout_fail("send");
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 5000);
    if (n >= 5000) timeout_fail("wait_idle");
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input bit use_reset);
    if (use_reset) reset = 1'b1;
    else abort = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    int ts, te;
    bit acc;

    // Pin the model itself against hand-worked ranges.
    axis_range(5, 3, 3, 64, ts, te);   chk("model_straddle_ts", ts, 0); chk("model_straddle_te", te, 1);
    axis_range(0, 8, 3, 64, ts, te);   chk("model_incl_ts", ts, 0);     chk("model_incl_te", te, 1);
    axis_range(16, 7, 3, 64, ts, te);  chk("model_align_ts", ts, 2);    chk("model_align_te", te, 2);
    axis_range(28, 15, 3, 4, ts, te);  chk("model_clip_ts", ts, 3);     chk("model_clip_te", te, 3);
    axis_range(40, 0, 3, 4, ts, te);   chk("model_clamp_ts", ts, 3);    chk("model_clamp_te", te, 3);
    build(5, 6, 3, 3, 64, 64);
    chk("model_q_size", exp_q.size(), 4);
    chk("model_q3_x", exp_q[3].x, 1);
    chk("model_q3_y", exp_q[3].y, 1);
    chk("model_q3_last", 32'(exp_q[3].last), 1);
    chk("model_q1_first", 32'(exp_q[1].first), 0);
    exp_q.delete();

    repeat (3) @(posedge clk);
    #1;
    started = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;

    send(16, 8, 7, 7);   wait_idle();
    send(5, 6, 3, 3);    wait_idle();
    send(0, 0, 8, 0);    wait_idle();

    // Stall mid-walk: first beat handshakes, then five cycles of backpressure.
    send(5, 6, 3, 3);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_idle();

    pic_w_tiles = XT'(4);
    send(28, 0, 15, 0);  wait_idle();
    send(40, 0, 0, 0);   wait_idle();
    pic_w_tiles = XT'(64);

    send(0, 0, 31, 31);
    repeat (2) begin @(posedge clk); #1; end
    pulse(1'b0);
    @(posedge clk);
    #1;
    send(5, 6, 3, 3);    wait_idle();

    send(0, 0, 31, 31);
    repeat (3) begin @(posedge clk); #1; end
    pulse(1'b1);
    @(posedge clk);
    #1;
    send(16, 8, 7, 7);   wait_idle();

    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      acc = req_valid && req_ready && !abort;
      @(posedge clk);
      #1;
      if (acc) req_valid = 1'b0;
      out_ready = ($urandom_range(0, 3) != 0);
      abort = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 19) == 0) begin
        pic_w_tiles = ($urandom_range(0, 7) == 0) ? XT'(511) : XT'($urandom_range(1, 40));
        pic_h_tiles = ($urandom_range(0, 7) == 0) ? YT'(511) : YT'($urandom_range(1, 40));
      end
      if (!req_valid && $urandom_range(0, 1) == 1) begin
        start_x    = ($urandom_range(0, 3) == 0) ? XW'($urandom_range(0, 4095)) : XW'($urandom_range(0, 300));
        start_y    = ($urandom_range(0, 3) == 0) ? YW'($urandom_range(0, 4095)) : YW'($urandom_range(0, 300));
        blk_width  = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 127)) : DW'($urandom_range(0, 24));
        blk_height = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 127)) : DW'($urandom_range(0, 24));
        req_valid  = 1'b1;
      end
    end
    req_valid = 1'b0;
    abort     = 1'b0;
    out_ready = 1'b1;
    wait_idle();
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
